// File: rtl/vga_rx_monitor.sv
// Receive-side VGA timing monitor: recovers pixel coordinates, checks line/frame lengths, reports lock.
// Define VGA_RX_COLOR_COUNT_EN to build the per-frame red/green active-pixel census.
module vga_rx_monitor #(
    parameter int H_TOTAL  = 800,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int H_ACTIVE = 640,
    parameter int V_TOTAL  = 525,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int V_ACTIVE = 480
) (
    input  logic        Clk,
    input  logic        reset,
    input  logic        pix_en,
    input  logic        vga_h_sync,
    input  logic        vga_v_sync,
    input  logic        vga_r,
    input  logic        vga_g,
    input  logic        vga_b,
    output logic [9:0]  Rx_X,
    output logic [9:0]  Rx_Y,
    output logic        Rx_Active,
    output logic        Locked,
    output logic        Frame_Done,
    output logic        Err_HLen,
    output logic        Err_VLen,
    output logic [18:0] Red_Cnt,
    output logic [18:0] Grn_Cnt
);

    localparam logic [10:0] H_OFF  = 11'(H_SYNC + H_BP);
    localparam logic [10:0] H_END  = 11'(H_SYNC + H_BP + H_ACTIVE);
    localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
    localparam logic [9:0]  V_OFF  = 10'(V_SYNC + V_BP);
    localparam logic [9:0]  V_END  = 10'(V_SYNC + V_BP + V_ACTIVE);
    localparam logic [10:0] V_LEN  = 11'(V_TOTAL);

    typedef enum logic [1:0] {
        ST_SEARCH  = 2'd0,
        ST_MEASURE = 2'd1,
        ST_LOCKED  = 2'd2
    } lock_state_t;

    logic        s_h_r, s_v_r, s_r_r, s_g_r, s_b_r;
    logic        p_h_r, p_v_r;
    logic        hedge_s, vedge_s;
    logic [10:0] hcnt_r;
    logic [9:0]  vcnt_r;
    logic        h_seen_r, v_seen_r, hlen_bad_r;
    logic [10:0] frame_len_s;
    logic        err_h_s, err_v_s, clean_frame_s;
    lock_state_t state_r, state_nxt_s;
    logic [10:0] hx_s;
    logic [9:0]  vy_s;
    logic        in_view_s;
    logic        frame_done_r, err_hlen_r, err_vlen_r;
    logic        rx_active_r;
    logic [9:0]  rx_x_r, rx_y_r;
    logic        unused_bits_s;

    // Sync/colour input sampling; idle-high sync history so reset never fakes an edge
    always_ff @(posedge Clk) begin
        if (reset) begin
            s_h_r <= 1'b1;
            s_v_r <= 1'b1;
            p_h_r <= 1'b1;
            p_v_r <= 1'b1;
            s_r_r <= 1'b0;
            s_g_r <= 1'b0;
            s_b_r <= 1'b0;
        end else if (pix_en) begin
            p_h_r <= s_h_r;
            p_v_r <= s_v_r;
            s_h_r <= vga_h_sync;
            s_v_r <= vga_v_sync;
            s_r_r <= vga_r;
            s_g_r <= vga_g;
            s_b_r <= vga_b;
        end
    end

    assign hedge_s       = p_h_r & ~s_h_r;
    assign vedge_s       = p_v_r & ~s_v_r;
    // A hedge landing on the vedge sample closes the last line of the frame
    assign frame_len_s   = {1'b0, vcnt_r} + {10'd0, hedge_s};
    assign err_h_s       = hedge_s & h_seen_r & (hcnt_r != H_LAST);
    assign err_v_s       = vedge_s & v_seen_r & (frame_len_s != V_LEN);
    assign clean_frame_s = ~hlen_bad_r & ~err_h_s & (frame_len_s == V_LEN);

    // Line/frame position counters and first-edge qualifiers
    always_ff @(posedge Clk) begin
        if (reset) begin
            hcnt_r     <= 11'd0;
            vcnt_r     <= 10'd0;
            h_seen_r   <= 1'b0;
            v_seen_r   <= 1'b0;
            hlen_bad_r <= 1'b0;
        end else if (pix_en) begin
            if (hedge_s) begin
                hcnt_r <= 11'd0;
            end else if (hcnt_r != 11'h7FF) begin
                hcnt_r <= hcnt_r + 11'd1;
            end
            if (vedge_s) begin
                vcnt_r <= 10'd0;
            end else if (hedge_s && (vcnt_r != 10'h3FF)) begin
                vcnt_r <= vcnt_r + 10'd1;
            end
            if (hedge_s) begin
                h_seen_r <= 1'b1;
            end
            if (vedge_s) begin
                v_seen_r   <= 1'b1;
                hlen_bad_r <= 1'b0;
            end else if (err_h_s) begin
                hlen_bad_r <= 1'b1;
            end
        end
    end

    // Single-Clk status pulses, cleared on every non-sample cycle
    always_ff @(posedge Clk) begin
        if (reset) begin
            frame_done_r <= 1'b0;
            err_hlen_r   <= 1'b0;
            err_vlen_r   <= 1'b0;
        end else if (pix_en) begin
            frame_done_r <= vedge_s;
            err_hlen_r   <= err_h_s;
            err_vlen_r   <= err_v_s;
        end else begin
            frame_done_r <= 1'b0;
            err_hlen_r   <= 1'b0;
            err_vlen_r   <= 1'b0;
        end
    end

    // Lock state register
    always_ff @(posedge Clk) begin
        if (reset) begin
            state_r <= ST_SEARCH;
        end else if (pix_en) begin
            state_r <= state_nxt_s;
        end
    end

    // Lock next-state: a fully clean frame promotes MEASURE, any length error demotes LOCKED
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_SEARCH: begin
                if (vedge_s) begin
                    state_nxt_s = ST_MEASURE;
                end else begin
                    state_nxt_s = ST_SEARCH;
                end
            end
            ST_MEASURE: begin
                if (vedge_s && clean_frame_s) begin
                    state_nxt_s = ST_LOCKED;
                end else begin
                    state_nxt_s = ST_MEASURE;
                end
            end
            ST_LOCKED: begin
                if (err_h_s || err_v_s) begin
                    state_nxt_s = ST_MEASURE;
                end else begin
                    state_nxt_s = ST_LOCKED;
                end
            end
            default: begin
                state_nxt_s = ST_SEARCH;
            end
        endcase
    end

    assign hx_s      = hcnt_r - H_OFF;
    assign vy_s      = vcnt_r - V_OFF;
    assign in_view_s = (hcnt_r >= H_OFF) && (hcnt_r < H_END) &&
                       (vcnt_r >= V_OFF) && (vcnt_r < V_END);

    // Registered coordinate outputs, forced to zero outside the locked visible area
    always_ff @(posedge Clk) begin
        if (reset) begin
            rx_active_r <= 1'b0;
            rx_x_r      <= 10'd0;
            rx_y_r      <= 10'd0;
        end else if (pix_en) begin
            if ((state_r == ST_LOCKED) && in_view_s) begin
                rx_active_r <= 1'b1;
                rx_x_r      <= hx_s[9:0];
                rx_y_r      <= vy_s;
            end else begin
                rx_active_r <= 1'b0;
                rx_x_r      <= 10'd0;
                rx_y_r      <= 10'd0;
            end
        end
    end

    assign Rx_X       = rx_x_r;
    assign Rx_Y       = rx_y_r;
    assign Rx_Active  = rx_active_r;
    assign Locked     = (state_r == ST_LOCKED);
    assign Frame_Done = frame_done_r;
    assign Err_HLen   = err_hlen_r;
    assign Err_VLen   = err_vlen_r;

`ifdef VGA_RX_COLOR_COUNT_EN
    logic        col_r_d1_r, col_g_d1_r, col_r_d2_r, col_g_d2_r;
    logic [18:0] red_acc_r, grn_acc_r, red_cnt_r, grn_cnt_r;
    logic        frame_clean_r;
    logic        publish_s;

    // Colour delay line aligning each sample with its registered coordinates
    always_ff @(posedge Clk) begin
        if (reset) begin
            col_r_d1_r <= 1'b0;
            col_g_d1_r <= 1'b0;
            col_r_d2_r <= 1'b0;
            col_g_d2_r <= 1'b0;
        end else if (pix_en) begin
            col_r_d1_r <= s_r_r;
            col_g_d1_r <= s_g_r;
            col_r_d2_r <= col_r_d1_r;
            col_g_d2_r <= col_g_d1_r;
        end
    end

    assign publish_s = frame_clean_r & (state_r == ST_LOCKED) & (state_nxt_s == ST_LOCKED);

    // Census accumulators; a frame is published only if lock held from its first to its closing vedge
    always_ff @(posedge Clk) begin
        if (reset) begin
            red_acc_r     <= 19'd0;
            grn_acc_r     <= 19'd0;
            red_cnt_r     <= 19'd0;
            grn_cnt_r     <= 19'd0;
            frame_clean_r <= 1'b0;
        end else if (pix_en) begin
            if (vedge_s) begin
                if (publish_s) begin
                    red_cnt_r <= red_acc_r;
                    grn_cnt_r <= grn_acc_r;
                end
                red_acc_r     <= {18'd0, rx_active_r & col_r_d2_r};
                grn_acc_r     <= {18'd0, rx_active_r & col_g_d2_r};
                frame_clean_r <= (state_nxt_s == ST_LOCKED);
            end else begin
                red_acc_r <= red_acc_r + {18'd0, rx_active_r & col_r_d2_r};
                grn_acc_r <= grn_acc_r + {18'd0, rx_active_r & col_g_d2_r};
                if (state_r != ST_LOCKED) begin
                    frame_clean_r <= 1'b0;
                end
            end
        end
    end

    assign Red_Cnt       = red_cnt_r;
    assign Grn_Cnt       = grn_cnt_r;
    assign unused_bits_s = ^{hx_s[10], s_b_r};
`else
    assign Red_Cnt       = 19'd0;
    assign Grn_Cnt       = 19'd0;
    assign unused_bits_s = ^{hx_s[10], s_b_r, s_r_r, s_g_r};
`endif

endmodule

// File: tb/tb_vga_rx_monitor.sv
// Directed scoreboard bench for vga_rx_monitor on a reduced 48x30 raster, pix_en every 2nd Clk.
`timescale 1ns/1ps
module tb_vga_rx_monitor;

    localparam int HT = 48, HS = 6, HB = 6, HA = 32;
    localparam int VT = 30, VS = 2, VB = 3, VA = 22;
    localparam int NONE = 1000;
    localparam int K_X = 0, K_Y = 1, K_ACT = 2, K_LOCK = 3, K_DONE = 4;
    localparam int K_HLEN = 5, K_VLEN = 6, K_RED = 7, K_GRN = 8;
`ifdef VGA_RX_COLOR_COUNT_EN
    localparam int RED_EXP = 16, GRN_EXP = 80;
`else
    localparam int RED_EXP = 0, GRN_EXP = 0;
`endif

    logic        Clk = 1'b0;
    logic        reset = 1'b1;
    logic        pix_en = 1'b0;
    logic        vga_h_sync = 1'b1, vga_v_sync = 1'b1;
    logic        vga_r = 1'b0, vga_g = 1'b0, vga_b = 1'b0;
    logic [9:0]  Rx_X, Rx_Y;
    logic        Rx_Active, Locked, Frame_Done, Err_HLen, Err_VLen;
    logic [18:0] Red_Cnt, Grn_Cnt;

    always #5 Clk = ~Clk;

    vga_rx_monitor #(
        .H_TOTAL(HT), .H_SYNC(HS), .H_BP(HB), .H_ACTIVE(HA),
        .V_TOTAL(VT), .V_SYNC(VS), .V_BP(VB), .V_ACTIVE(VA)
    ) dut (
        .Clk(Clk), .reset(reset), .pix_en(pix_en),
        .vga_h_sync(vga_h_sync), .vga_v_sync(vga_v_sync),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
        .Rx_X(Rx_X), .Rx_Y(Rx_Y), .Rx_Active(Rx_Active), .Locked(Locked),
        .Frame_Done(Frame_Done), .Err_HLen(Err_HLen), .Err_VLen(Err_VLen),
        .Red_Cnt(Red_Cnt), .Grn_Cnt(Grn_Cnt)
    );

    typedef struct packed { int due; int kind; int value; } exp_t;
    exp_t sb[$];
    int n_cmp = 0, n_bad = 0, pix_idx = 0;
    int cnt_done = 0, cnt_hlen = 0, cnt_vlen = 0;

    function automatic string kind_name(input int k);
        case (k)
            K_X:     return "rx_x";
            K_Y:     return "rx_y";
            K_ACT:   return "rx_active";
            K_LOCK:  return "locked";
            K_DONE:  return "frame_done";
            K_HLEN:  return "err_hlen";
            K_VLEN:  return "err_vlen";
            K_RED:   return "red_cnt";
            K_GRN:   return "grn_cnt";
            default: return "unknown";
        endcase
    endfunction

    function automatic logic [31:0] obs_of(input int k);
        case (k)
            K_X:     return {22'd0, Rx_X};
            K_Y:     return {22'd0, Rx_Y};
            K_ACT:   return {31'd0, Rx_Active};
            K_LOCK:  return {31'd0, Locked};
            K_DONE:  return {31'd0, Frame_Done};
            K_HLEN:  return {31'd0, Err_HLen};
            K_VLEN:  return {31'd0, Err_VLen};
            K_RED:   return {13'd0, Red_Cnt};
            K_GRN:   return {13'd0, Grn_Cnt};
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic push(input int due, input int kind, input int value);
        exp_t e;
        e.due = due; e.kind = kind; e.value = value;
        sb.push_back(e);
    endtask

    // One pixel: drive at a negedge with pix_en high for one Clk, observe at the next negedge.
    task automatic pixel(input logic h, input logic v, input logic r, input logic g);
        @(negedge Clk);
        check("pulse_width", {29'd0, Frame_Done, Err_HLen, Err_VLen}, 32'd0);
        pix_en = 1'b1; vga_h_sync = h; vga_v_sync = v;
        vga_r = r; vga_g = g; vga_b = r & g;
        @(negedge Clk);
        pix_en = 1'b0;
        cnt_done += int'(Frame_Done);
        cnt_hlen += int'(Err_HLen);
        cnt_vlen += int'(Err_VLen);
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].due == pix_idx) begin
                check(kind_name(sb[i].kind), obs_of(sb[i].kind), sb[i].value);
                sb.delete(i);
            end
        end
        pix_idx++;
    endtask

    task automatic do_reset();
        @(negedge Clk);
        pix_en = 1'b0; reset = 1'b1;
        @(negedge Clk);
        @(negedge Clk);
        for (int k = 0; k < 9; k++) check({"rst_", kind_name(k)}, obs_of(k), 32'd0);
        reset = 1'b0;
    endtask

    // mode: 0 blank, 1 red 4x4 box + green 8x10 region, 2 all red
    task automatic frame(input int nlines, input int short_line, input int mode,
                         input int lock_exp, input int verr_exp, input bit coords,
                         input int red_exp, input int grn_exp, input int reset_line);
        logic h, v, r, g;
        int len, ax, ay;
        for (int ln = 0; ln < nlines; ln++) begin
            len = (ln == short_line) ? HT - 1 : HT;
            for (int px = 0; px < len; px++) begin
                h = (px >= HS);
                v = (ln >= VS);
                ax = px - (HS + HB);
                ay = ln - (VS + VB);
                case (mode)
                    1: begin
                        r = (ax >= 2 && ax < 6 && ay >= 3 && ay < 7);
                        g = (ax >= 12 && ax < 20 && ay >= 8 && ay < 18);
                    end
                    2: begin r = 1'b1; g = 1'b0; end
                    default: begin r = 1'b0; g = 1'b0; end
                endcase
                if (ln == 0 && px == 0) begin
                    push(pix_idx + 1, K_DONE, 1);
                    push(pix_idx + 1, K_VLEN, verr_exp);
                    push(pix_idx + 1, K_HLEN, 0);
                    push(pix_idx + 1, K_LOCK, lock_exp);
                    push(pix_idx + 1, K_RED, red_exp);
                    push(pix_idx + 1, K_GRN, grn_exp);
                end
                if (px == 0 && ln == short_line + 1) begin
                    push(pix_idx + 1, K_HLEN, 1);
                    push(pix_idx + 1, K_LOCK, 0);
                end
                if (coords) begin
                    if (ay == 0 && ax == -1) push(pix_idx + 2, K_ACT, 0);
                    if ((ay == 0 && ax == 0) || (ay == 4 && ax == 7) ||
                        (ay == VA - 1 && ax == HA - 1)) begin
                        push(pix_idx + 2, K_ACT, 1);
                        push(pix_idx + 2, K_X, ax);
                        push(pix_idx + 2, K_Y, ay);
                    end
                    if (ay == VA - 1 && ax == HA) begin
                        push(pix_idx + 2, K_ACT, 0);
                        push(pix_idx + 2, K_X, 0);
                        push(pix_idx + 2, K_Y, 0);
                    end
                end
                if (ln == reset_line && px == 20) do_reset();
                pixel(h, v, r, g);
            end
        end
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation exceeded its time budget");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) @(negedge Clk);
        for (int k = 0; k < 9; k++) check({"rst_", kind_name(k)}, obs_of(k), 32'd0);
        reset = 1'b0;
        //    lines    short mode lock verr coords red      grn      reset
        frame(VT,      NONE, 0,   0,   0,   1'b0, 0,       0,       NONE); // search -> measure
        frame(VT,      NONE, 1,   1,   0,   1'b1, 0,       0,       NONE); // lock, census frame
        frame(VT,      10,   0,   1,   0,   1'b0, RED_EXP, GRN_EXP, NONE); // short line 10
        frame(VT,      NONE, 0,   0,   0,   1'b0, RED_EXP, GRN_EXP, NONE); // clean measure frame
        frame(VT + 1,  NONE, 2,   1,   0,   1'b1, RED_EXP, GRN_EXP, NONE); // relocked, long frame
        frame(VT,      NONE, 0,   0,   1,   1'b0, RED_EXP, GRN_EXP, NONE); // vlen error at start
        frame(VT,      NONE, 0,   1,   0,   1'b0, RED_EXP, GRN_EXP, 10);   // reset mid-frame
        frame(VT,      NONE, 0,   0,   0,   1'b0, 0,       0,       NONE); // first post-reset vedge
        frame(VT,      NONE, 1,   1,   0,   1'b1, 0,       0,       NONE); // relock, census frame
        frame(4,       NONE, 0,   1,   0,   1'b0, RED_EXP, GRN_EXP, NONE); // census published
        check("frame_done_total", cnt_done, 10);
        check("err_hlen_total", cnt_hlen, 1);
        check("err_vlen_total", cnt_vlen, 1);
        check("scoreboard_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
